// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the instruction prefetch stage.
//   pf_state_t       - request FSM states (RUN issues/keeps data, DISCARD drops one ack)
//   WORD_BYTES       - PC increment per fetched instruction word
//   DEFAULT_RESET_PC - default first fetch address after reset
package pipeline_pkg;

  typedef enum logic [0:0] {
    PF_RUN     = 1'b0,
    PF_DISCARD = 1'b1
  } pf_state_t;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: synchronous FIFO holding {pc, instr} entries for the prefetch stage.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset (control only)
//   push, wdata  - write one entry (caller guarantees the FIFO is not full)
//   pop          - drop the head entry (ignored when empty or flushing)
//   flush        - empty the FIFO at this edge; wins over push and pop
//   rdata        - head entry, straight from storage
//   count        - number of stored entries, 0..DEPTH
module pf_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;

  assign pop_ok = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: sequential instruction prefetch with a single outstanding
// memory read and a small {pc, instr} queue toward decode.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   jump_flg, jump_target   - one-cycle redirect; flushes queue and in-flight read
//   mem_req, mem_addr       - read request, held with a stable address until mem_ack
//   mem_ack, mem_rdata      - read completion and instruction word
//   out_valid, out_instr,
//   out_pc, out_ready       - head of queue to decode, valid/ready handshake
module prefetch_buffer
  import pipeline_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_flg,
  input  logic [31:0] jump_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pf_state_t        state;
  pf_state_t        state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ack;
  logic             push;
  logic             pop;
  logic             issue;
  logic [63:0]      head;

  assign ack       = mem_req && mem_ack;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !jump_flg;
  assign push      = ack && (state == PF_RUN) && !jump_flg;
  assign out_pc    = head[63:32];
  assign out_instr = head[31:0];

  pf_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (64)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (jump_flg),
    .wdata ({mem_addr, mem_rdata}),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    count_next    = count + CNT_W'(push) - CNT_W'(pop);
    issue         = 1'b0;

    if (jump_flg) begin
      fetch_pc_next = jump_target;
      count_next    = '0;
    end

    unique case (state)
      PF_RUN: begin
        // A request cannot be withdrawn, so a redirect with a read still in
        // flight must swallow that read's ack later.
        if (jump_flg && mem_req && !mem_ack) begin
          state_next = PF_DISCARD;
        end
      end
      PF_DISCARD: begin
        if (ack) begin
          state_next = PF_RUN;
        end
      end
      default: state_next = PF_RUN;
    endcase

    // Issuing only while a slot is free reserves room for the pending push.
    issue = (!mem_req || ack) && (state_next == PF_RUN) &&
            (count_next < CNT_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= PF_RUN;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= fetch_pc_next;
        fetch_pc <= fetch_pc_next + WORD_BYTES;
      end else begin
        if (ack) begin
          mem_req <= 1'b0;
        end
        fetch_pc <= fetch_pc_next;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: directed self-checking bench for prefetch_buffer.
// A small memory responder acks after a programmable number of wait cycles
// and returns addr ^ 32'hA5A5_0000.
module tb_prefetch_buffer;

  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        jump_flg;
  logic [31:0] jump_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int n_checks;
  int n_pass;

  logic [3:0] lat;
  logic [3:0] wait_cnt;

  prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jump_flg    (jump_flg),
    .jump_target (jump_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory responder: counts wait cycles of the current request.
  always @(posedge clock) begin
    if (!mem_req || mem_ack) wait_cnt <= 4'd0;
    else                     wait_cnt <= wait_cnt + 4'd1;
  end
  assign mem_ack   = mem_req && (wait_cnt >= lat);
  assign mem_rdata = mem_addr ^ XOR_K;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    jump_flg = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bit seen_old;
    bit got;
    n_checks    = 0;
    n_pass      = 0;
    wait_cnt    = 4'd0;
    lat         = 4'd0;
    jump_flg    = 1'b0;
    jump_target = 32'h0;
    out_ready   = 1'b1;

    // Reset state and zero-wait streaming.
    do_reset();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    tick();
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    check("first_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_pc", out_pc, 32'(i * 4));
      check("stream_instr", out_instr, 32'(i * 4) ^ XOR_K);
    end

    // Backpressure: four entries fill the queue, then requests stop.
    out_ready = 1'b0;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 5) check("full_req_low", {31'd0, mem_req}, 32'd0);
    end
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_head", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_pc", out_pc, 32'(i * 4));
      check("drain_instr", out_instr, 32'(i * 4) ^ XOR_K);
    end

    // Redirect while a slow read of 0x8 is pending.
    lat = 4'd3;
    do_reset();
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (mem_req && mem_addr == 32'h8 && !mem_ack) got = 1'b1;
    end
    check("slow_pending8", {31'd0, got}, 32'd1);
    jump_target = 32'h100;
    jump_flg    = 1'b1;
    tick();
    jump_flg = 1'b0;
    check("disc_req_held", {31'd0, mem_req}, 32'd1);
    check("disc_addr_held", mem_addr, 32'h8);
    check("disc_valid", {31'd0, out_valid}, 32'd0);
    seen_old = 1'b0;
    got      = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (out_valid && out_pc == 32'h8) seen_old = 1'b1;
      if (out_valid) got = 1'b1;
    end
    check("disc_timeout", {31'd0, got}, 32'd1);
    check("disc_no_old", {31'd0, seen_old}, 32'd0);
    check("disc_first_pc", out_pc, 32'h100);
    check("disc_first_instr", out_instr, 32'h100 ^ XOR_K);

    // Redirect coinciding with an ack: no discard phase.
    lat = 4'd0;
    do_reset();
    tick();
    tick();
    tick();
    check("jack_pre_addr", mem_addr, 32'h8);
    jump_target = 32'h200;
    jump_flg    = 1'b1;
    tick();
    jump_flg = 1'b0;
    check("jack_addr", mem_addr, 32'h200);
    check("jack_req", {31'd0, mem_req}, 32'd1);
    check("jack_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("jack_out_pc", out_pc, 32'h200);
    check("jack_next_addr", mem_addr, 32'h204);

    // Redirect coinciding with a pop while three entries are queued.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    check("jpop_head", out_pc, 32'h0);
    out_ready   = 1'b1;
    jump_target = 32'h300;
    jump_flg    = 1'b1;
    tick();
    jump_flg = 1'b0;
    check("jpop_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("jpop_pc", out_pc, 32'h300 + 32'(i * 4));
    end

    // Reset mid-stream with two entries queued and a read pending.
    out_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    lat = 4'd9;
    check("mrst_pre_valid", {31'd0, out_valid}, 32'd1);
    check("mrst_pre_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    lat   = 4'd0;
    tick();
    check("mrst_first_req", {31'd0, mem_req}, 32'd1);
    check("mrst_first_addr", mem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
